// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and counter widths.
// Ports: none (package).
// Imported by spi_clkgen and spi_master.
package spi_pkg;

    // Divider counter covers CLK_DIV up to 255; bit counter needs to reach 8.
    localparam int DIV_CNT_W     = 8;
    localparam int BIT_CNT_W     = 4;
    localparam int BITS_PER_BYTE = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        WAIT  = 3'd4,
        GAP   = 3'd5
    } spi_state_e;

endpackage

// File: rtl/spi_clkgen.sv
// Tick generator: tick_o pulses on every CLK_DIV-th cycle while en_i is high.
// Ports: clk_i/rstn_i clock and async active-low reset, en_i run enable, tick_o one-cycle tick.
// Counter restarts from zero whenever en_i drops, so the first tick after enabling lands CLK_DIV cycles later.
module spi_clkgen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [DIV_CNT_W-1:0] TERM = DIV_CNT_W'(CLK_DIV - 1);

    logic [DIV_CNT_W-1:0] cnt_q;
    logic [DIV_CNT_W-1:0] cnt_d;

    always_comb begin
        tick_o = en_i && (cnt_q == TERM);
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master, one byte per tx handshake; csn_o held low across bytes until a byte tagged last.
// Ports: clk_i/rstn_i; tx_data_i/tx_last_i/tx_valid_i/tx_ready_o byte input; rx_data_o/rx_valid_o byte output;
//        sck_o/sdo_o/sdi_i/csn_o SPI pins. All outputs registered. Accept to rx_valid_o = 17*CLK_DIV cycles.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 2
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_last_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       sck_o,
    output logic       sdo_o,
    input  logic       sdi_i,
    output logic       csn_o
);

    localparam logic [BIT_CNT_W-1:0] LAST_SHIFT = BIT_CNT_W'(BITS_PER_BYTE - 1);
    localparam logic [BIT_CNT_W-1:0] ALL_BITS   = BIT_CNT_W'(BITS_PER_BYTE);
    localparam logic [DIV_CNT_W-1:0] GAP_TERM   = DIV_CNT_W'(CS_GAP - 1);

    spi_state_e           state_q, state_d;
    logic [6:0]           tx_shift_q, tx_shift_d;   // bits still to send after the one on sdo
    logic                 last_q, last_d;
    logic [7:0]           rx_shift_q, rx_shift_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 sck_q, sck_d;
    logic                 sdo_q, sdo_d;
    logic                 csn_q, csn_d;
    logic                 tx_ready_q, tx_ready_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;     // counts sck falling edges in the frame
    logic [DIV_CNT_W-1:0] gap_cnt_q, gap_cnt_d;

    logic div_en;
    logic tick;
    logic accept;

    // The divider runs through setup, both sck phases and the post-byte hold.
    assign div_en = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);
    assign accept = tx_valid_i && tx_ready_q;

    spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en_i   (div_en),
        .tick_o (tick)
    );

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        last_d     = last_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sck_d      = sck_q;
        sdo_d      = sdo_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        unique case (state_q)
            IDLE, WAIT: begin
                if (accept) begin
                    sdo_d      = tx_data_i[7];
                    tx_shift_d = tx_data_i[6:0];
                    last_d     = tx_last_i;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                // First rising edge: sdi is sampled on the same clk edge sck goes high.
                if (tick) begin
                    state_d    = XFER;
                    sck_d      = 1'b1;
                    rx_shift_d = {rx_shift_q[6:0], sdi_i};
                    bit_cnt_d  = '0;
                end
            end
            XFER: begin
                if (tick) begin
                    if (sck_q) begin
                        // Falling edge; the eighth one leaves sdo on bit 0.
                        sck_d     = 1'b0;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (bit_cnt_q < LAST_SHIFT) begin
                            sdo_d      = tx_shift_q[6];
                            tx_shift_d = {tx_shift_q[5:0], 1'b0};
                        end
                    end else if (bit_cnt_q == ALL_BITS) begin
                        // Low phase of the eighth period done: byte complete.
                        state_d    = HOLD;
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        sck_d      = 1'b1;
                        rx_shift_d = {rx_shift_q[6:0], sdi_i};
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (last_q) begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_TERM) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + DIV_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered versions of these track the state being entered.
        csn_d      = (state_d == IDLE) || (state_d == GAP);
        tx_ready_d = (state_d == IDLE) || (state_d == WAIT);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            last_q     <= 1'b0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sck_q      <= 1'b0;
            sdo_q      <= 1'b0;
            csn_q      <= 1'b1;
            tx_ready_q <= 1'b0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            last_q     <= last_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sck_q      <= sck_d;
            sdo_q      <= sdo_d;
            csn_q      <= csn_d;
            tx_ready_q <= tx_ready_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign tx_ready_o = tx_ready_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign sck_o      = sck_q;
    assign sdo_o      = sdo_q;
    assign csn_o      = csn_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: CLK_DIV=2 instance with loopback or shift-register slave, CLK_DIV=1 instance with sdi tied high.
// Ports: none.
// Directed vectors with hand-computed expectations plus multi-cycle sequences.
module tb_spi_master;

    localparam int T = 10;

    logic clk = 1'b0;
    logic rstn;
    logic [7:0] tx_data;
    logic tx_last;
    logic tx_valid0, tx_valid1;

    logic       rdy0, rxv0, sck0, sdo0, csn0, sdi0;
    logic [7:0] rxd0;
    logic       rdy1, rxv1, sck1, sdo1, csn1;
    logic [7:0] rxd1;

    logic       loop_mode = 1'b1;
    logic [7:0] slv_reg = 8'h00;
    logic       slv_in = 1'b0;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  rise0 = 0;
    int  csn_fall0 = 0;
    int  csn_rise0 = 0;
    int  rxv0_cnt = 0;
    int  acc0_cnt = 0;
    time t_prev = 0;
    time t_last = 0;

    always #(T/2) clk = ~clk;

    assign sdi0 = loop_mode ? sdo0 : slv_reg[7];

    spi_master #(.CLK_DIV(2), .CS_GAP(2)) u_dut (
        .clk_i(clk), .rstn_i(rstn),
        .tx_data_i(tx_data), .tx_last_i(tx_last), .tx_valid_i(tx_valid0), .tx_ready_o(rdy0),
        .rx_data_o(rxd0), .rx_valid_o(rxv0),
        .sck_o(sck0), .sdo_o(sdo0), .sdi_i(sdi0), .csn_o(csn0)
    );

    spi_master #(.CLK_DIV(1), .CS_GAP(2)) u_dut1 (
        .clk_i(clk), .rstn_i(rstn),
        .tx_data_i(tx_data), .tx_last_i(tx_last), .tx_valid_i(tx_valid1), .tx_ready_o(rdy1),
        .rx_data_o(rxd1), .rx_valid_o(rxv1),
        .sck_o(sck1), .sdo_o(sdo1), .sdi_i(1'b1), .csn_o(csn1)
    );

    // Mode-0 shift-register slave: sample on rise, shift on fall, MSB out.
    always @(posedge sck0) begin
        rise0  <= rise0 + 1;
        slv_in <= sdo0;
    end
    always @(negedge sck0) slv_reg <= {slv_reg[6:0], slv_in};

    always @(negedge csn0) csn_fall0 <= csn_fall0 + 1;
    always @(posedge csn0) csn_rise0 <= csn_rise0 + 1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rxv0 === 1'b1) rxv0_cnt <= rxv0_cnt + 1;
        if (tx_valid0 && rdy0 === 1'b1) acc0_cnt <= acc0_cnt + 1;
    end

    always @(posedge sck1) begin
        t_prev <= t_last;
        t_last <= $time;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with its edge count.
    task automatic send(input bit which, input logic [7:0] d, input bit last, input bit keep,
                        output int acc_cyc);
        tx_data = d;
        tx_last = last;
        if (which) tx_valid1 = 1'b1; else tx_valid0 = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 400; i++) begin
            if ((which ? rdy1 : rdy0) === 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                acc_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (!keep) begin
            tx_valid0 = 1'b0;
            tx_valid1 = 1'b0;
        end
        if (acc_cyc < 0) timeout("send_accept");
    endtask

    task automatic wait_rx(input bit which, output int rx_cyc, output logic [7:0] d);
        rx_cyc = -1;
        d = 8'h00;
        for (int i = 0; i < 500; i++) begin
            if ((which ? rxv1 : rxv0) === 1'b1) begin
                rx_cyc = cyc;
                d = which ? rxd1 : rxd0;
                break;
            end
            @(negedge clk);
        end
        if (rx_cyc < 0) timeout("rx_valid");
    endtask

    task automatic wait_ready0();
        int n;
        n = 0;
        while (rdy0 !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) timeout("ready");
    endtask

    typedef struct {
        logic [7:0] tx;
        bit         loop;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int acc, acc2, rxc, n, g, r0, f0, c0, a0, v0;
        logic [7:0] d;
        bit seen_rdy;

        // Slave holds the previously transmitted byte in either mode.
        vecs[0] = '{tx: 8'hA5, loop: 1'b1, exp: 8'hA5};
        vecs[1] = '{tx: 8'h00, loop: 1'b1, exp: 8'h00};
        vecs[2] = '{tx: 8'hFF, loop: 1'b1, exp: 8'hFF};
        vecs[3] = '{tx: 8'h3C, loop: 1'b0, exp: 8'hFF};
        vecs[4] = '{tx: 8'hC3, loop: 1'b0, exp: 8'h3C};
        vecs[5] = '{tx: 8'h5A, loop: 1'b0, exp: 8'hC3};

        rstn = 1'b0;
        tx_data = 8'h00;
        tx_last = 1'b0;
        tx_valid0 = 1'b0;
        tx_valid1 = 1'b0;

        #12;
        check("reset_csn", csn0, 1);
        check("reset_sck", sck0, 0);
        check("reset_sdo", sdo0, 0);
        check("reset_ready", rdy0, 0);
        check("reset_rxv", rxv0, 0);
        check("reset_rxd", rxd0, 0);
        check("reset_csn1", csn1, 1);

        @(negedge clk);
        rstn = 1'b1;
        #1 check("ready_before_edge", rdy0, 0);
        @(negedge clk);
        check("ready_first_edge", rdy0, 1);

        for (int i = 0; i < 6; i++) begin
            loop_mode = vecs[i].loop;
            send(1'b0, vecs[i].tx, 1'b1, 1'b0, acc);
            wait_rx(1'b0, rxc, d);
            check($sformatf("vec%0d_rxdata", i), d, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), rxc - acc, 34);
            @(negedge clk);
            check($sformatf("vec%0d_rxv_pulse", i), rxv0, 0);
            n = 0;
            while (csn0 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
            g = 0;
            while (rdy0 !== 1'b1 && g < 100) begin
                if (csn0 !== 1'b1) g = 1000;
                @(negedge clk);
                g++;
            end
            check($sformatf("vec%0d_gap", i), g, 2);
        end

        // Two bytes in one chip-select window.
        loop_mode = 1'b1;
        r0 = rise0; f0 = csn_fall0; c0 = csn_rise0;
        send(1'b0, 8'h01, 1'b0, 1'b0, acc);
        wait_rx(1'b0, rxc, d);
        check("two_byte_rx0", d, 8'h01);
        send(1'b0, 8'h80, 1'b1, 1'b0, acc2);
        wait_rx(1'b0, rxc, d);
        check("two_byte_rx1", d, 8'h80);
        check("two_byte_lat1", rxc - acc2, 34);
        check("two_byte_csn_low", csn_rise0 - c0, 0);
        wait_ready0();
        check("two_byte_rises", rise0 - r0, 16);
        check("two_byte_csn_falls", csn_fall0 - f0, 1);
        check("two_byte_csn_rises", csn_rise0 - c0, 1);

        // tx_valid held with changing data through the frame.
        a0 = acc0_cnt;
        seen_rdy = 1'b0;
        send(1'b0, 8'h96, 1'b1, 1'b1, acc);
        n = 0;
        while (rxv0 !== 1'b1 && n < 200) begin
            if (rdy0 === 1'b1) seen_rdy = 1'b1;
            tx_data = 8'($urandom);
            tx_last = 1'($urandom);
            @(negedge clk);
            n++;
        end
        tx_valid0 = 1'b0;
        check("hold_valid_rx", rxd0, 8'h96);
        check("hold_valid_no_ready", seen_rdy, 0);
        wait_ready0();
        check("hold_valid_accepts", acc0_cnt - a0, 1);

        // Reset mid-frame after the fourth sck rise.
        r0 = rise0;
        send(1'b0, 8'hA5, 1'b1, 1'b0, acc);
        n = 0;
        while (rise0 - r0 < 4 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout("fourth_rise");
        check("pre_reset_sck_high", sck0, 1);
        v0 = rxv0_cnt;
        #2 rstn = 1'b0;
        #1;
        check("async_csn", csn0, 1);
        check("async_sck", sck0, 0);
        repeat (3) @(negedge clk);
        check("abort_rxd", rxd0, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("abort_ready", rdy0, 1);
        check("abort_no_rxv", rxv0_cnt - v0, 0);
        send(1'b0, 8'h3C, 1'b1, 1'b0, acc);
        wait_rx(1'b0, rxc, d);
        check("after_reset_rx", d, 8'h3C);
        check("after_reset_lat", rxc - acc, 34);
        wait_ready0();

        // CLK_DIV=1 instance, sdi tied high.
        send(1'b1, 8'h00, 1'b1, 1'b0, acc);
        wait_rx(1'b1, rxc, d);
        check("div1_rx", d, 8'hFF);
        check("div1_lat", rxc - acc, 17);
        check("div1_sck_period", 32'(t_last - t_prev), 2 * T);
        repeat (4) @(negedge clk);
        check("div1_csn_end", csn1, 1);
        check("div1_sck_end", sck1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
